// File: rtl/encoder_pkg.sv
// Shared constants and helpers for the rotary-encoder sampling scheduler.
package encoder_pkg;
    localparam int ENC_PRESCALE_SHIFT = 6;
    localparam int ENC_PERIOD_W       = 8;

    typedef logic [ENC_PERIOD_W-1:0] enc_period_t;

    // A zero period would never expire, so it is treated as "every tick".
    function automatic enc_period_t enc_reload(input enc_period_t per);
        return (per == '0) ? enc_period_t'(1) : per;
    endfunction
endpackage

// File: rtl/encoder_sample_sched_rr_arbiter.sv
// Combinational round-robin picker: first requester strictly after ptr, wrapping.
module rr_arbiter #(
    parameter int N = 4
) (
    input  logic [N-1:0] req,
    input  logic [2:0]   ptr,
    output logic [N-1:0] gnt,
    output logic [2:0]   idx,
    output logic         any
);
    always_comb begin
        gnt = '0;
        idx = '0;
        any = 1'b0;
        for (int k = 1; k <= N; k++) begin
            if (!any && req[(int'(ptr) + k) % N]) begin
                any = 1'b1;
                idx = 3'((int'(ptr) + k) % N);
                gnt[(int'(ptr) + k) % N] = 1'b1;
            end
        end
    end
endmodule

// File: rtl/encoder_sample_sched.sv
// Base-tick prescaler, per-channel tick counters and a round-robin strobe scheduler
// so that all encoder channels share a single sampling slot per clock.
module encoder_sample_sched
    import encoder_pkg::*;
#(
    parameter int NCH   = 4,
    parameter int WIDTH = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [7:0]                base_div,
    input  logic [NCH-1:0]            ch_en,
    input  logic [ENC_PERIOD_W*NCH-1:0] ch_period,
    input  logic [NCH-1:0]            overrun_clr,
    output logic [NCH-1:0]            sample_strobe,
    output logic [2:0]                grant_idx,
    output logic [NCH-1:0]            pending,
    output logic [NCH-1:0]            overrun
);
    logic [WIDTH-1:0] count;
    logic [WIDTH-1:0] cmp;
    logic             tick_r;
    logic [2:0]       rr_ptr;
    logic [NCH-1:0]   expire;
    logic [NCH-1:0]   gnt;
    logic [2:0]       win_idx;
    logic             win_any;

    assign cmp = WIDTH'(base_div) << ENC_PRESCALE_SHIFT;

    always_ff @(posedge clk) begin
        if (reset) begin
            count  <= '0;
            tick_r <= 1'b0;
        end else if (count >= cmp) begin
            count  <= '0;
            tick_r <= 1'b1;
        end else begin
            count  <= count + 1'b1;
            tick_r <= 1'b0;
        end
    end

    for (genvar g = 0; g < NCH; g++) begin : g_ch
        enc_period_t cnt;
        enc_period_t per;

        assign per       = ch_period[ENC_PERIOD_W*g +: ENC_PERIOD_W];
        assign expire[g] = ch_en[g] & tick_r & (cnt <= enc_period_t'(1));

        // Disabled channels keep reloading so a re-enable starts a full period.
        always_ff @(posedge clk) begin
            if (reset)
                cnt <= enc_period_t'(1);
            else if (!ch_en[g])
                cnt <= enc_reload(per);
            else if (tick_r)
                cnt <= expire[g] ? enc_reload(per) : cnt - enc_period_t'(1);
        end
    end

    rr_arbiter #(.N(NCH)) u_arb (
        .req (pending),
        .ptr (rr_ptr),
        .gnt (gnt),
        .idx (win_idx),
        .any (win_any)
    );

    // A re-expiry on the granted channel re-arms it rather than counting as overrun.
    always_ff @(posedge clk) begin
        if (reset) begin
            pending       <= '0;
            overrun       <= '0;
            sample_strobe <= '0;
            grant_idx     <= '0;
            rr_ptr        <= '0;
        end else begin
            pending <= ch_en & (expire | (pending & ~gnt));
            overrun <= (overrun & ~overrun_clr) | (expire & pending & ~gnt);
            if (win_any) begin
                sample_strobe <= gnt;
                grant_idx     <= win_idx;
                rr_ptr        <= win_idx;
            end else begin
                sample_strobe <= '0;
            end
        end
    end
endmodule

// File: tb/tb_encoder_sample_sched.sv
// Self-checking bench for encoder_sample_sched: behavioural model, vector table,
// directed corner sequences and randomized traffic.
module tb_encoder_sample_sched;
    localparam int NCH = 4;

    logic             clk = 1'b0;
    logic             reset;
    logic [7:0]       base_div;
    logic [NCH-1:0]   ch_en;
    logic [8*NCH-1:0] ch_period;
    logic [NCH-1:0]   overrun_clr;
    logic [NCH-1:0]   sample_strobe;
    logic [2:0]       grant_idx;
    logic [NCH-1:0]   pending;
    logic [NCH-1:0]   overrun;

    encoder_sample_sched #(.NCH(NCH), .WIDTH(16)) dut (
        .clk           (clk),
        .reset         (reset),
        .base_div      (base_div),
        .ch_en         (ch_en),
        .ch_period     (ch_period),
        .overrun_clr   (overrun_clr),
        .sample_strobe (sample_strobe),
        .grant_idx     (grant_idx),
        .pending       (pending),
        .overrun       (overrun)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    // Reference model state
    int           m_count;
    bit           m_tick;
    int           m_cnt[NCH];
    bit [NCH-1:0] m_pend, m_ovr, m_strobe;
    int           m_gidx, m_rr;

    typedef struct {
        logic [3:0] clr;
        logic [3:0] strobe;
        int         gidx;
        logic [3:0] pend;
        logic [3:0] ovr;
    } vec_t;

    function automatic int reload(input int p);
        return (p == 0) ? 1 : p;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    // Advance model and DUT by one clock, then compare every output.
    task automatic step();
        int           win, p, n_count, n_gidx, n_rr;
        bit           n_tick, ex;
        int           n_cnt[NCH];
        bit [NCH-1:0] n_pend, n_ovr, n_strobe;
        if (reset) begin
            n_count = 0; n_tick = 0; n_pend = '0; n_ovr = '0;
            n_strobe = '0; n_gidx = 0; n_rr = 0;
            for (int i = 0; i < NCH; i++) n_cnt[i] = 1;
        end else begin
            win = -1;
            for (int k = 1; k <= NCH; k++)
                if (win < 0 && m_pend[(m_rr + k) % NCH]) win = (m_rr + k) % NCH;
            n_strobe = '0; n_gidx = m_gidx; n_rr = m_rr;
            if (win >= 0) begin
                n_strobe[win] = 1'b1; n_gidx = win; n_rr = win;
            end
            for (int i = 0; i < NCH; i++) begin
                p = int'(ch_period[8*i +: 8]);
                if (!ch_en[i]) begin
                    n_cnt[i]  = reload(p);
                    n_pend[i] = 1'b0;
                    n_ovr[i]  = m_ovr[i] && !overrun_clr[i];
                end else begin
                    ex = m_tick && (m_cnt[i] <= 1);
                    if (!m_tick)  n_cnt[i] = m_cnt[i];
                    else if (ex)  n_cnt[i] = reload(p);
                    else          n_cnt[i] = m_cnt[i] - 1;
                    n_pend[i] = ex || (m_pend[i] && win != i);
                    if (ex && m_pend[i] && win != i) n_ovr[i] = 1'b1;
                    else if (overrun_clr[i])         n_ovr[i] = 1'b0;
                    else                             n_ovr[i] = m_ovr[i];
                end
            end
            if (m_count >= int'(base_div) * 64) begin
                n_count = 0; n_tick = 1'b1;
            end else begin
                n_count = m_count + 1; n_tick = 1'b0;
            end
        end
        @(posedge clk);
        #1;
        m_count = n_count; m_tick = n_tick; m_cnt = n_cnt; m_pend = n_pend;
        m_ovr = n_ovr; m_strobe = n_strobe; m_gidx = n_gidx; m_rr = n_rr;
        cyc++;
        chk("model_strobe",  32'(sample_strobe), 32'(m_strobe));
        chk("model_gidx",    32'(grant_idx),     32'(m_gidx));
        chk("model_pending", 32'(pending),       32'(m_pend));
        chk("model_overrun", 32'(overrun),       32'(m_ovr));
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        chk("reset_strobe",  32'(sample_strobe), 32'h0);
        chk("reset_pending", 32'(pending),       32'h0);
        chk("reset_overrun", 32'(overrun),       32'h0);
        reset = 1'b0;
        cyc = 0;
    endtask

    vec_t tbl[9];
    int   strobe_cyc[$];

    initial begin
        reset = 1'b1; base_div = '0; ch_en = '0; ch_period = '0; overrun_clr = '0;
        step();

        // Single slow channel: tick every 65 clocks, strobe every other tick
        base_div = 8'd1; ch_en = 4'b0001; ch_period = {8'd0, 8'd0, 8'd0, 8'd2};
        do_reset();
        for (int i = 0; i < 340; i++) begin
            step();
            if (sample_strobe != 0) begin
                strobe_cyc.push_back(cyc);
                chk("t1_gidx", 32'(grant_idx), 32'd0);
            end
        end
        chk("t1_nstrobes", 32'(strobe_cyc.size()), 32'd3);
        if (strobe_cyc.size() == 3) begin
            chk("t1_first",  32'(strobe_cyc[0]), 32'd67);
            chk("t1_second", 32'(strobe_cyc[1]), 32'd197);
            chk("t1_third",  32'(strobe_cyc[2]), 32'd327);
        end
        chk("t1_overrun", 32'(overrun), 32'h0);

        // All channels every tick: rotation 1,2,3,0 and overrun accumulation
        tbl[0] = '{4'b0000, 4'b0000, 0, 4'b0000, 4'b0000};
        tbl[1] = '{4'b0000, 4'b0000, 0, 4'b1111, 4'b0000};
        tbl[2] = '{4'b0000, 4'b0010, 1, 4'b1111, 4'b1101};
        tbl[3] = '{4'b0000, 4'b0100, 2, 4'b1111, 4'b1111};
        tbl[4] = '{4'b0000, 4'b1000, 3, 4'b1111, 4'b1111};
        tbl[5] = '{4'b0000, 4'b0001, 0, 4'b1111, 4'b1111};
        tbl[6] = '{4'b0000, 4'b0010, 1, 4'b1111, 4'b1111};
        tbl[7] = '{4'b1111, 4'b0100, 2, 4'b1111, 4'b1011};
        tbl[8] = '{4'b0000, 4'b1000, 3, 4'b1111, 4'b1111};
        base_div = 8'd0; ch_en = 4'b1111; ch_period = {8'd1, 8'd1, 8'd1, 8'd1};
        do_reset();
        for (int i = 0; i < 9; i++) begin
            overrun_clr = tbl[i].clr;
            step();
            overrun_clr = '0;
            chk("t2_strobe",  32'(sample_strobe), 32'(tbl[i].strobe));
            chk("t2_gidx",    32'(grant_idx),     32'(tbl[i].gidx));
            chk("t2_pending", 32'(pending),       32'(tbl[i].pend));
            chk("t2_overrun", 32'(overrun),       32'(tbl[i].ovr));
        end

        // Reset mid-operation with pending and overrun set
        reset = 1'b1;
        step();
        chk("t6_strobe",  32'(sample_strobe), 32'h0);
        chk("t6_gidx",    32'(grant_idx),     32'h0);
        chk("t6_pending", 32'(pending),       32'h0);
        chk("t6_overrun", 32'(overrun),       32'h0);
        reset = 1'b0; cyc = 0;
        step();
        chk("t6_pend_s1", 32'(pending), 32'h0);
        step();
        chk("t6_pend_s2", 32'(pending), 32'hf);

        // Two channels expiring together: higher after rr_ptr=0 goes first
        ch_en = 4'b0011; ch_period = {8'd0, 8'd0, 8'd4, 8'd4};
        do_reset();
        step(); step();
        chk("t3_pend", 32'(pending), 32'h3);
        step();
        chk("t3_first",  32'(sample_strobe), 32'h2);
        chk("t3_gidx1",  32'(grant_idx),     32'd1);
        step();
        chk("t3_second", 32'(sample_strobe), 32'h1);
        chk("t3_gidx0",  32'(grant_idx),     32'd0);
        for (int i = 0; i < 4; i++) step();
        chk("t3_overrun", 32'(overrun), 32'h0);

        // Disable a pending channel before it wins, then re-enable with period 3
        ch_en = 4'b1110; ch_period = {8'd200, 8'd5, 8'd200, 8'd0};
        do_reset();
        step(); step();
        chk("t4_pend", 32'(pending), 32'he);
        ch_en = 4'b1010;
        step();
        chk("t4_strobe1", 32'(sample_strobe), 32'h2);
        chk("t4_pend_drop", 32'(pending), 32'h8);
        step();
        chk("t4_strobe3", 32'(sample_strobe), 32'h8);
        for (int i = 0; i < 4; i++) begin
            step();
            chk("t4_no_ch2", 32'(sample_strobe[2]), 32'h0);
        end
        ch_period[23:16] = 8'd3;
        step();
        ch_en = 4'b1110;
        step(); step();
        chk("t4_not_yet", 32'(pending[2]), 32'h0);
        step();
        chk("t4_reexpire", 32'(pending[2]), 32'h1);
        step();
        chk("t4_restrobe", 32'(sample_strobe), 32'h4);

        // Period 0 behaves as period 1
        ch_en = 4'b0001; ch_period = '0;
        do_reset();
        step(); step();
        for (int i = 0; i < 8; i++) begin
            step();
            chk("t5_strobe",  32'(sample_strobe), 32'h1);
            chk("t5_pending", 32'(pending),       32'h1);
        end
        chk("t5_overrun", 32'(overrun), 32'h0);

        // Randomized traffic against the model
        base_div = 8'd0;
        for (int i = 0; i < 3000; i++) begin
            reset = ($urandom_range(0, 199) == 0);
            if ($urandom_range(0, 19) == 0) ch_en = NCH'($urandom);
            if ($urandom_range(0, 29) == 0)
                ch_period[8*$urandom_range(0, NCH-1) +: 8] = 8'($urandom_range(0, 4));
            overrun_clr = ($urandom_range(0, 9) == 0) ? NCH'($urandom) : '0;
            if ($urandom_range(0, 499) == 0) base_div = 8'($urandom_range(0, 1));
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
